// File: rtl/jogada_scheduler.sv
// jogada_scheduler -- round sequencer for the LED reaction game.
//
// Each round runs in this order:
//   1. Ask the random LED datapath for a frame.
//   2. Wait for the frame to finish shifting out.
//   3. Open a timed window on the player buttons and score hit or miss.
//   4. Blank the strip and hold a short gap.
// After N_RODADAS rounds the block parks in FIM, and the score stays on display.
//
// Ports
//   clock, reset     : system clock; synchronous active-high reset
//   iniciar          : start request (accepted in INICIAL and FIM only)
//   frame_pronto     : frame fully shifted out (1-cycle pulse)
//   led_sorteado     : lit LED index, valid with frame_pronto
//   botoes           : synchronized/debounced button levels, bit i = LED i
//   gerar_jogada     : pulse, draw and send a new random frame
//   apagar           : pulse, send an all-off frame
//   acertou/errou/timeout : result pulses
//   pontos, rodada   : hit count (saturating) and rounds completed
//   em_jogo, fim_jogo: game running / game over
//   db_estado        : raw state encoding for the debug display
module jogada_scheduler #(
  parameter int N_LEDS          = 11,
  parameter int N_RODADAS       = 10,
  parameter int TEMPO_RESPOSTA  = 50_000_000,
  parameter int TEMPO_INTERVALO = 12_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              frame_pronto,
  input  logic [3:0]        led_sorteado,
  input  logic [N_LEDS-1:0] botoes,
  output logic              gerar_jogada,
  output logic              apagar,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [7:0]        pontos,
  output logic [7:0]        rodada,
  output logic              em_jogo,
  output logic              fim_jogo,
  output logic [3:0]        db_estado
);

  localparam int TMAX = (TEMPO_RESPOSTA > TEMPO_INTERVALO) ? TEMPO_RESPOSTA : TEMPO_INTERVALO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    GERA          = 4'd2,
    ESPERA_FRAME  = 4'd3,
    ESPERA_JOGADA = 4'd4,
    ACERTO        = 4'd5,
    ERRO          = 4'd6,
    INTERVALO     = 4'd7,
    FIM           = 4'd8
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        alvo_q, alvo_d;
  logic [N_LEDS-1:0] botoes_prev_q;
  logic [7:0]        pontos_q, pontos_d;
  logic [7:0]        rodada_q, rodada_d;
  logic              timeout_q, timeout_d;

  logic [N_LEDS-1:0] novo;
  logic [N_LEDS-1:0] alvo_oh;
  logic              alvo_invalido;
  logic              fim_resposta;
  logic              fim_intervalo;

  // Only fresh presses count. A button already held when the window opens is ignored.
  assign novo          = botoes & ~botoes_prev_q;
  assign alvo_oh       = {{(N_LEDS-1){1'b0}}, 1'b1} << alvo_q;
  assign alvo_invalido = ({28'd0, alvo_q} >= 32'(N_LEDS));
  assign fim_resposta  = (timer_q == TW'(TEMPO_RESPOSTA - 1));
  assign fim_intervalo = (timer_q == TW'(TEMPO_INTERVALO - 1));

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    alvo_d    = alvo_q;
    pontos_d  = pontos_q;
    rodada_d  = rodada_q;
    timeout_d = 1'b0;
    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        pontos_d = 8'd0;
        rodada_d = 8'd0;
        estado_d = GERA;
      end
      GERA: estado_d = ESPERA_FRAME;
      ESPERA_FRAME: if (frame_pronto) begin
        alvo_d   = led_sorteado;
        timer_d  = '0;
        estado_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        timer_d = timer_q + TW'(1);
        // A press wins over expiry in the same cycle, so timeout only fires with no press.
        if (alvo_invalido) estado_d = ERRO;
        else if (novo != '0) estado_d = (novo == alvo_oh) ? ACERTO : ERRO;
        else if (fim_resposta) begin
          estado_d  = ERRO;
          timeout_d = 1'b1;
        end
      end
      ACERTO: begin
        if (pontos_q != 8'hFF) pontos_d = pontos_q + 8'd1;
        timer_d  = '0;
        estado_d = INTERVALO;
      end
      ERRO: begin
        timer_d  = '0;
        estado_d = INTERVALO;
      end
      INTERVALO: begin
        timer_d = timer_q + TW'(1);
        if (fim_intervalo) begin
          timer_d  = '0;
          rodada_d = rodada_q + 8'd1;
          estado_d = ((rodada_q + 8'd1) == 8'(N_RODADAS)) ? FIM : GERA;
        end
      end
      FIM: if (iniciar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= INICIAL;
      timer_q       <= '0;
      alvo_q        <= 4'd0;
      botoes_prev_q <= '0;
      pontos_q      <= 8'd0;
      rodada_q      <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      timer_q       <= timer_d;
      alvo_q        <= alvo_d;
      botoes_prev_q <= botoes;
      pontos_q      <= pontos_d;
      rodada_q      <= rodada_d;
      timeout_q     <= timeout_d;
    end
  end

  // The timer is zero only on the first INTERVALO cycle, so it marks the entry.
  assign gerar_jogada = (estado_q == GERA);
  assign apagar       = (estado_q == INTERVALO) && (timer_q == '0);
  assign acertou      = (estado_q == ACERTO);
  assign errou        = (estado_q == ERRO);
  assign timeout      = (estado_q == ERRO) && timeout_q;
  assign pontos       = pontos_q;
  assign rodada       = rodada_q;
  assign em_jogo      = (estado_q != INICIAL) && (estado_q != FIM);
  assign fim_jogo     = (estado_q == FIM);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_jogada_scheduler.sv
// Directed bench for jogada_scheduler with small timing parameters
// (3 rounds, 20-cycle window, 5-cycle gap).
// Inputs are driven, and outputs checked, at the falling edge.
module tb_jogada_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        frame_pronto = 1'b0;
  logic [3:0]  led_sorteado = 4'd0;
  logic [10:0] botoes = '0;
  logic        gerar_jogada, apagar, acertou, errou, timeout, em_jogo, fim_jogo;
  logic [7:0]  pontos, rodada;
  logic [3:0]  db_estado;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  jogada_scheduler #(
    .N_LEDS(11), .N_RODADAS(3), .TEMPO_RESPOSTA(20), .TEMPO_INTERVALO(5)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .frame_pronto(frame_pronto),
    .led_sorteado(led_sorteado), .botoes(botoes), .gerar_jogada(gerar_jogada),
    .apagar(apagar), .acertou(acertou), .errou(errou), .timeout(timeout),
    .pontos(pontos), .rodada(rodada), .em_jogo(em_jogo), .fim_jogo(fim_jogo),
    .db_estado(db_estado)
  );

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // From INICIAL/FIM: iniciar -> PREPARA -> GERA with the counters cleared.
  task automatic start_game();
    iniciar = 1'b1; cyc(); iniciar = 1'b0;
    chk("prepara_state", db_estado, 1);
    chk("prepara_em_jogo", em_jogo, 1);
    cyc();
    chk("gera_pulse", gerar_jogada, 1);
    chk("gera_pontos_clr", pontos, 0);
    chk("gera_rodada_clr", rodada, 0);
  endtask

  // From GERA: wait two cycles in ESPERA_FRAME, then deliver the frame.
  // The task ends on the first window cycle.
  task automatic send_frame(input logic [3:0] led, input logic poke_ini);
    cyc();
    chk("espera_frame_state", db_estado, 3);
    chk("gera_one_cycle", gerar_jogada, 0);
    iniciar = poke_ini; cyc(); iniciar = 1'b0;
    chk("espera_frame_hold", db_estado, 3);
    frame_pronto = 1'b1; led_sorteado = led; cyc();
    frame_pronto = 1'b0; led_sorteado = 4'd0;
    chk("espera_jogada_state", db_estado, 4);
  endtask

  // The press rises after `waits` window cycles, so it is evaluated at timer = waits.
  task automatic press(input logic [10:0] mask, input int waits);
    for (int i = 0; i < waits; i++) cyc();
    botoes = botoes | mask; cyc();
  endtask

  // Let the window run out with no press: the result comes 20 cycles after entry.
  task automatic expire();
    for (int i = 0; i < 19; i++) begin
      cyc();
      chk("window_open", db_estado, 4);
    end
    cyc();
    chk("timeout_errou", errou, 1);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_no_hit", acertou, 0);
  endtask

  // From ACERTO/ERRO: 5 gap cycles, then GERA or FIM.
  task automatic interval(input int exp_rodada, input logic to_fim);
    cyc(); botoes = '0;
    chk("apagar_entry", apagar, 1);
    chk("intervalo_state", db_estado, 7);
    chk("result_one_cycle", acertou | errou, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("apagar_once", apagar, 0);
      chk("no_early_gera", gerar_jogada, 0);
    end
    cyc();
    if (to_fim) chk("fim_state", db_estado, 8);
    else        chk("next_gera", gerar_jogada, 1);
    chk("rodada_count", rodada, exp_rodada);
  endtask

  initial begin
    // Reset state
    cyc(); cyc(); reset = 1'b0;
    chk("rst_state", db_estado, 0);
    chk("rst_pulses", {gerar_jogada, apagar, acertou, errou, timeout, em_jogo, fim_jogo}, 0);
    chk("rst_pontos", pontos, 0);
    chk("rst_rodada", rodada, 0);
    cyc();
    chk("idle_hold", db_estado, 0);

    // Game 1: hit, wrong press, hit on the final window cycle
    start_game();
    send_frame(4'd4, 1'b0);
    press(11'h1 << 4, 3);
    chk("hit_acertou", acertou, 1);
    chk("hit_errou", errou, 0);
    chk("hit_pontos_pre", pontos, 0);
    interval(1, 1'b0);
    chk("hit_pontos", pontos, 1);

    send_frame(4'd2, 1'b0);
    press(11'h1 << 7, 0);
    chk("wrong_errou", errou, 1);
    chk("wrong_timeout", timeout, 0);
    chk("wrong_acertou", acertou, 0);
    interval(2, 1'b0);
    chk("wrong_pontos", pontos, 1);

    send_frame(4'd5, 1'b0);
    press(11'h1 << 5, 19);
    chk("edge_acertou", acertou, 1);
    chk("edge_timeout", timeout, 0);
    interval(3, 1'b1);
    chk("game1_pontos", pontos, 2);
    chk("game1_fim", fim_jogo, 1);
    chk("game1_em_jogo", em_jogo, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("fim_no_gera", gerar_jogada, 0);
      chk("fim_hold", db_estado, 8);
    end
    chk("fim_pontos_hold", pontos, 2);
    chk("fim_rodada_hold", rodada, 3);

    // Game 2: multi-press, timeout, held button
    start_game();
    send_frame(4'd2, 1'b0);
    press((11'h1 << 2) | (11'h1 << 3), 0);
    chk("multi_errou", errou, 1);
    chk("multi_acertou", acertou, 0);
    chk("multi_timeout", timeout, 0);
    interval(1, 1'b0);

    send_frame(4'd0, 1'b0);
    expire();
    interval(2, 1'b0);

    botoes = 11'h1 << 5;  // held before the frame arrives
    send_frame(4'd5, 1'b0);
    expire();
    interval(3, 1'b1);
    chk("game2_pontos", pontos, 0);

    // Game 3: iniciar ignored mid-round, out-of-range target, reset mid-round
    start_game();
    send_frame(4'd12, 1'b1);
    cyc();
    chk("bad_alvo_errou", errou, 1);
    chk("bad_alvo_timeout", timeout, 0);
    interval(1, 1'b0);

    send_frame(4'd4, 1'b0);
    press(11'h1 << 4, 0);
    chk("g3_acertou", acertou, 1);
    interval(2, 1'b0);

    send_frame(4'd3, 1'b0);
    cyc();
    chk("pre_rst_pontos", pontos, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_state", db_estado, 0);
    chk("midrst_pulses", {gerar_jogada, apagar, acertou, errou, timeout, em_jogo, fim_jogo}, 0);
    chk("midrst_pontos", pontos, 0);
    chk("midrst_rodada", rodada, 0);
    frame_pronto = 1'b1; cyc(); frame_pronto = 1'b0;
    chk("frame_ignored_idle", db_estado, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
